// File: rtl/pll_reconfig_master.sv
// pll_reconfig_master: Avalon-MM initiator that retunes one Cyclone V PLL counter per request (optional PLL_RECFG_READBACK_EN verifies the counter register).
module pll_reconfig_master #(
  parameter int LOCK_STABLE  = 16,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int POLL_LIMIT   = 1024
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_sel,
  input  logic [7:0]  req_hi,
  input  logic [7:0]  req_lo,
  input  logic        req_odd,
  input  logic        req_bypass,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic        mgmt_read,
  output logic [31:0] mgmt_writedata,
  input  logic [31:0] mgmt_readdata,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);
  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int PW = $clog2(POLL_LIMIT + 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(LOCK_STABLE);
  localparam logic [TW-1:0] TMO_MAX = TW'(LOCK_TIMEOUT);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_LIMIT - 1);
  typedef enum logic [3:0] {
    S_IDLE, S_WR_MODE, S_WR_CNT, S_WR_START, S_RD_STATUS,
`ifdef PLL_RECFG_READBACK_EN
    S_READBACK,
`endif
    S_WAIT_LOCK, S_DONE, S_ERR
  } state_t;
  state_t r_state;
  logic [4:0] r_sel;
  logic [7:0] r_hi, r_lo;
  logic r_odd, r_bypass, r_write, r_read, r_done, r_err;
  logic [5:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0] r_err_code;
  logic [PW-1:0] r_poll;
  logic [SW-1:0] r_stable;
  logic [TW-1:0] r_tmo;
  logic w_sel_m, w_unused;
  logic [5:0] w_cnt_addr;
  logic [31:0] w_cnt_data;
  logic [SW-1:0] w_stable_nx;
  logic [TW-1:0] w_tmo_nx;
  state_t w_after_status;
  assign w_sel_m = r_sel == 5'd18;
  assign w_cnt_addr = w_sel_m ? 6'h04 : 6'h05;
  assign w_cnt_data = w_sel_m ? {14'b0, r_odd, r_bypass, r_hi, r_lo} : {9'b0, r_sel, r_odd, r_bypass, r_hi, r_lo};
  assign w_stable_nx = !pll_locked ? '0 : (r_stable == STABLE_MAX ? r_stable : r_stable + 1'b1);
  assign w_tmo_nx = r_tmo == TMO_MAX ? r_tmo : r_tmo + 1'b1;
`ifdef PLL_RECFG_READBACK_EN
  assign w_after_status = S_READBACK;
`else
  assign w_after_status = S_WAIT_LOCK;
`endif
  assign w_unused = ^mgmt_readdata;
  assign req_ready = r_state == S_IDLE;
  assign busy = r_state != S_IDLE;
  assign mgmt_address = r_addr;
  assign mgmt_write = r_write;
  assign mgmt_read = r_read;
  assign mgmt_writedata = r_wdata;
  assign done = r_done;
  assign err = r_err;
  assign err_code = r_err_code;
  // Request capture, write/poll sequencing with one idle cycle between strobes, lock qualification
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sel <= '0;
      r_hi <= '0;
      r_lo <= '0;
      r_odd <= 1'b0;
      r_bypass <= 1'b0;
      r_write <= 1'b0;
      r_read <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_done <= 1'b0;
      r_err <= 1'b0;
      r_err_code <= '0;
      r_poll <= '0;
      r_stable <= '0;
      r_tmo <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_sel <= req_sel;
          r_hi <= req_hi;
          r_lo <= req_lo;
          r_odd <= req_odd;
          r_bypass <= req_bypass;
          r_err_code <= 2'd0;
          r_poll <= '0;
          r_stable <= '0;
          r_tmo <= '0;
          if (req_sel > 5'd18) begin
            r_state <= S_ERR;
            r_err <= 1'b1;
            r_err_code <= 2'd3;
          end else r_state <= S_WR_MODE;
        end
        S_WR_MODE: if (!r_write) begin
          r_write <= 1'b1;
          r_addr <= 6'h00;
          r_wdata <= 32'h1;
        end else if (!mgmt_waitrequest) begin
          r_write <= 1'b0;
          r_state <= S_WR_CNT;
        end
        S_WR_CNT: if (!r_write) begin
          r_write <= 1'b1;
          r_addr <= w_cnt_addr;
          r_wdata <= w_cnt_data;
        end else if (!mgmt_waitrequest) begin
          r_write <= 1'b0;
          r_state <= S_WR_START;
        end
        S_WR_START: if (!r_write) begin
          r_write <= 1'b1;
          r_addr <= 6'h02;
          r_wdata <= 32'h1;
        end else if (!mgmt_waitrequest) begin
          r_write <= 1'b0;
          r_state <= S_RD_STATUS;
        end
        S_RD_STATUS: if (!r_read) begin
          r_read <= 1'b1;
          r_addr <= 6'h01;
        end else if (!mgmt_waitrequest) begin
          r_read <= 1'b0;
          if (mgmt_readdata[0]) r_state <= w_after_status;
          else if (r_poll == POLL_LAST) begin
            r_state <= S_ERR;
            r_err <= 1'b1;
            r_err_code <= 2'd1;
          end else r_poll <= r_poll + 1'b1;
        end
`ifdef PLL_RECFG_READBACK_EN
        S_READBACK: if (!r_read) begin
          r_read <= 1'b1;
          r_addr <= w_cnt_addr;
        end else if (!mgmt_waitrequest) begin
          r_read <= 1'b0;
          if (mgmt_readdata[17:0] == w_cnt_data[17:0]) r_state <= S_WAIT_LOCK;
          else begin
            r_state <= S_ERR;
            r_err <= 1'b1;
            r_err_code <= 2'd3;
          end
        end
`endif
        S_WAIT_LOCK: begin
          r_stable <= w_stable_nx;
          r_tmo <= w_tmo_nx;
          if (w_stable_nx == STABLE_MAX) begin
            r_state <= S_DONE;
            r_done <= 1'b1;
          end else if (w_tmo_nx == TMO_MAX) begin
            r_state <= S_ERR;
            r_err <= 1'b1;
            r_err_code <= 2'd2;
          end
        end
        S_DONE: begin
          r_done <= 1'b0;
          r_state <= S_IDLE;
        end
        S_ERR: begin
          r_err <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pll_reconfig_master.sv
// tb_pll_reconfig_master: scoreboarded bench with an Avalon-MM slave model for pll_reconfig_master.
module tb_pll_reconfig_master;
  localparam int LS = 16;
  localparam int LT = 200;
  localparam int PL = 8;
`ifdef PLL_RECFG_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif
  typedef struct packed {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
  } xfer_t;
  logic refclk = 0, rst = 1, req_valid = 0, req_odd = 0, req_bypass = 0, pll_locked = 0, mgmt_waitrequest = 0;
  logic [4:0] req_sel = 0;
  logic [7:0] req_hi = 0, req_lo = 0;
  logic req_ready, mgmt_write, mgmt_read, busy, done, err;
  logic [5:0] mgmt_address;
  logic [31:0] mgmt_writedata, mgmt_readdata;
  logic [1:0] err_code;
  logic [31:0] status_word = 0, rb_word = 0;
  xfer_t sb[$];
  int errors = 0, checks = 0, cyc = 0;
  int n_wr_str = 0, n_rd_str = 0, n_status = 0, n_rd_other = 0, cyc_last_rd = 0;
  int stall_n = 0, stall_addr = -1, stall_cnt = 0, done_on = 1000, status_base = 0;
  logic prev_strobe = 0, prev_cmp = 0, cap_wr = 0;
  logic [5:0] cap_addr = 0;
  logic [31:0] cap_data = 0;

  assign mgmt_readdata = (mgmt_address == 6'h01) ? status_word : rb_word;

  pll_reconfig_master #(.LOCK_STABLE(LS), .LOCK_TIMEOUT(LT), .POLL_LIMIT(PL)) dut (
    .refclk(refclk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_hi(req_hi), .req_lo(req_lo), .req_odd(req_odd), .req_bypass(req_bypass),
    .mgmt_address(mgmt_address), .mgmt_write(mgmt_write), .mgmt_read(mgmt_read),
    .mgmt_writedata(mgmt_writedata), .mgmt_readdata(mgmt_readdata), .mgmt_waitrequest(mgmt_waitrequest),
    .pll_locked(pll_locked), .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  always #10 refclk = ~refclk;
  always @(posedge refclk) cyc++;

  // Slave model and bus monitor: decides waitrequest for the coming edge, then checks the transfer
  always @(negedge refclk) begin
    xfer_t e;
    logic strobe;
    strobe = mgmt_write | mgmt_read;
    if (!strobe) stall_cnt = 0;
    mgmt_waitrequest = strobe && (stall_addr < 0 || int'(mgmt_address) == stall_addr) && stall_cnt < stall_n;
    if (mgmt_waitrequest) stall_cnt++;
    status_word = {31'b0, (n_status - status_base + 1) >= done_on};
    if (prev_cmp) begin
      checks++;
      if (strobe) begin
        errors++;
        $display("FAIL b2b_strobe: got strobe=1 in the cycle after a completed transfer, required 0");
      end
    end
    if (strobe && !prev_strobe) begin
      if (mgmt_write) n_wr_str++;
      if (mgmt_read) n_rd_str++;
      cap_wr = mgmt_write;
      cap_addr = mgmt_address;
      cap_data = mgmt_writedata;
    end else if (strobe) begin
      checks++;
      if ({mgmt_write, mgmt_address, mgmt_writedata} !== {cap_wr, cap_addr, cap_data}) begin
        errors++;
        $display("FAIL stall_hold: got wr=%0b addr=%h data=%h, required wr=%0b addr=%h data=%h",
                 mgmt_write, mgmt_address, mgmt_writedata, cap_wr, cap_addr, cap_data);
      end
    end
    prev_cmp = 0;
    if (strobe && !mgmt_waitrequest) begin
      prev_cmp = 1;
      stall_cnt = 0;
      if (mgmt_read) begin
        cyc_last_rd = cyc;
        if (mgmt_address == 6'h01) n_status++;
        else n_rd_other++;
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL bus_unexpected: got wr=%0b addr=%h data=%h, required no transfer", mgmt_write, mgmt_address, mgmt_writedata);
      end else begin
        e = sb.pop_front();
        if (mgmt_write !== e.wr || mgmt_address !== e.addr || (e.wr && mgmt_writedata !== e.data)) begin
          errors++;
          $display("FAIL bus_xfer: got wr=%0b addr=%h data=%h, required wr=%0b addr=%h data=%h",
                   mgmt_write, mgmt_address, mgmt_writedata, e.wr, e.addr, e.data);
        end
      end
    end
    prev_strobe = strobe;
  end

  task automatic push(input logic wr, input logic [5:0] a, input logic [31:0] d);
    sb.push_back('{wr, a, d});
  endtask

  task automatic send(input logic [4:0] s, input logic [7:0] h, input logic [7:0] l, input logic o, input logic b);
    @(negedge refclk);
    req_sel = s;
    req_hi = h;
    req_lo = l;
    req_odd = o;
    req_bypass = b;
    req_valid = 1;
    @(negedge refclk);
    req_valid = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge refclk);
    checks++;
    if ({req_ready, busy, done, err, mgmt_write, mgmt_read, err_code} !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%0b busy=%0b done=%0b err=%0b wr=%0b rd=%0b code=%0d, required 1 0 0 0 0 0 0",
               req_ready, busy, done, err, mgmt_write, mgmt_read, err_code);
    end
    rst = 0;
    @(negedge refclk);
    checks++;
    if ({req_ready, busy, mgmt_address, mgmt_writedata} !== {1'b1, 1'b0, 6'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_release: got rdy=%0b busy=%0b addr=%h data=%h, required 1 0 00 00000000", req_ready, busy, mgmt_address, mgmt_writedata);
    end
  endtask

  task automatic test_basic();
    int n, base_other;
    status_base = n_status;
    done_on = 3;
    pll_locked = 1;
    rb_word = 32'h0008_0808;
    base_other = n_rd_other;
    push(1, 6'h00, 32'h1);
    push(1, 6'h05, 32'h0008_0808);
    push(1, 6'h02, 32'h1);
    repeat (3) push(0, 6'h01, 32'h0);
    if (RB == 1) push(0, 6'h05, 32'h0);
    send(5'd2, 8'd8, 8'd8, 1'b0, 1'b0);
    n = 0;
    while (!done && !err && n < 400) begin
      @(negedge refclk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL basic_done: got done=%0b err=%0b after %0d cycles, required done=1", done, err, n);
    end
    checks++;
    if (cyc - cyc_last_rd != LS + 1) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles from last read to done, required %0d", cyc - cyc_last_rd, LS + 1);
    end
    checks++;
    if (err_code !== 2'd0) begin
      errors++;
      $display("FAIL basic_code: got err_code=%0d, required 0", err_code);
    end
    checks++;
    if (n_status - status_base != 3 || n_rd_other - base_other != RB) begin
      errors++;
      $display("FAIL basic_reads: got status=%0d other=%0d, required 3 %0d", n_status - status_base, n_rd_other - base_other, RB);
    end
    @(negedge refclk);
    checks++;
    if (done !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_pulse: got done=%0b ready=%0b, required 0 1", done, req_ready);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL basic_sb: got %0d pending transfers, required 0", sb.size());
    end
  endtask

  task automatic test_stall();
    int n, bw, br;
    status_base = n_status;
    done_on = 1;
    stall_n = 5;
    rb_word = 32'h0002_1010;
    bw = n_wr_str;
    br = n_rd_str;
    push(1, 6'h00, 32'h1);
    push(1, 6'h04, 32'h0002_1010);
    push(1, 6'h02, 32'h1);
    push(0, 6'h01, 32'h0);
    if (RB == 1) push(0, 6'h04, 32'h0);
    send(5'd18, 8'd16, 8'd16, 1'b1, 1'b0);
    n = 0;
    while (!done && !err && n < 600) begin
      @(negedge refclk);
      n++;
    end
    stall_n = 0;
    checks++;
    if (done !== 1'b1 || err_code !== 2'd0) begin
      errors++;
      $display("FAIL stall_done: got done=%0b err_code=%0d, required 1 0", done, err_code);
    end
    checks++;
    if (n_wr_str - bw != 3 || n_rd_str - br != 1 + RB) begin
      errors++;
      $display("FAIL stall_strobes: got writes=%0d reads=%0d, required 3 %0d", n_wr_str - bw, n_rd_str - br, 1 + RB);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL stall_sb: got %0d pending transfers, required 0", sb.size());
    end
  endtask

  task automatic test_illegal();
    int bw, br;
    bw = n_wr_str;
    br = n_rd_str;
    send(5'd25, 8'd1, 8'd1, 1'b0, 1'b0);
    checks++;
    if (err !== 1'b1 || err_code !== 2'd3) begin
      errors++;
      $display("FAIL illegal_err: got err=%0b err_code=%0d, required 1 3", err, err_code);
    end
    @(negedge refclk);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL illegal_pulse: got err=%0b, required 0", err);
    end
    repeat (5) @(negedge refclk);
    checks++;
    if (err_code !== 2'd3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL illegal_hold: got err_code=%0d busy=%0b, required 3 0", err_code, busy);
    end
    checks++;
    if (n_wr_str != bw || n_rd_str != br) begin
      errors++;
      $display("FAIL illegal_bus: got %0d writes %0d reads, required 0 0", n_wr_str - bw, n_rd_str - br);
    end
  endtask

  task automatic test_poll_timeout();
    int n;
    status_base = n_status;
    done_on = 1000;
    push(1, 6'h00, 32'h1);
    push(1, 6'h05, 32'h001D_0305);
    push(1, 6'h02, 32'h1);
    repeat (PL) push(0, 6'h01, 32'h0);
    send(5'd7, 8'd3, 8'd5, 1'b0, 1'b1);
    n = 0;
    while (!done && !err && n < 400) begin
      @(negedge refclk);
      n++;
    end
    checks++;
    if (err !== 1'b1 || err_code !== 2'd1) begin
      errors++;
      $display("FAIL poll_err: got err=%0b done=%0b err_code=%0d, required err=1 code=1", err, done, err_code);
    end
    checks++;
    if (n_status - status_base != PL) begin
      errors++;
      $display("FAIL poll_count: got %0d status reads, required %0d", n_status - status_base, PL);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL poll_sb: got %0d pending transfers, required 0", sb.size());
    end
  endtask

  task automatic test_lock_timeout();
    int n;
    status_base = n_status;
    done_on = 1;
    pll_locked = 0;
    rb_word = 32'h0000_0101;
    push(1, 6'h00, 32'h1);
    push(1, 6'h05, 32'h0000_0101);
    push(1, 6'h02, 32'h1);
    push(0, 6'h01, 32'h0);
    if (RB == 1) push(0, 6'h05, 32'h0);
    send(5'd0, 8'd1, 8'd1, 1'b0, 1'b0);
    n = 0;
    while (!done && !err && n < 800) begin
      @(negedge refclk);
      n++;
      if (n % 10 == 0) pll_locked = ~pll_locked;
    end
    pll_locked = 1;
    checks++;
    if (err !== 1'b1 || err_code !== 2'd2) begin
      errors++;
      $display("FAIL lock_err: got err=%0b done=%0b err_code=%0d, required err=1 code=2", err, done, err_code);
    end
    checks++;
    if (cyc - cyc_last_rd != LT + 1) begin
      errors++;
      $display("FAIL lock_latency: got %0d cycles from last read to err, required %0d", cyc - cyc_last_rd, LT + 1);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL lock_sb: got %0d pending transfers, required 0", sb.size());
    end
  endtask

`ifdef PLL_RECFG_READBACK_EN
  task automatic test_readback();
    int n;
    status_base = n_status;
    done_on = 1;
    rb_word = 32'h0008_0809;
    push(1, 6'h00, 32'h1);
    push(1, 6'h05, 32'h0008_0808);
    push(1, 6'h02, 32'h1);
    push(0, 6'h01, 32'h0);
    push(0, 6'h05, 32'h0);
    send(5'd2, 8'd8, 8'd8, 1'b0, 1'b0);
    n = 0;
    while (!done && !err && n < 400) begin
      @(negedge refclk);
      n++;
    end
    checks++;
    if (err !== 1'b1 || err_code !== 2'd3) begin
      errors++;
      $display("FAIL readback_err: got err=%0b done=%0b err_code=%0d, required err=1 code=3", err, done, err_code);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL readback_sb: got %0d pending transfers, required 0", sb.size());
    end
  endtask
`endif

  task automatic test_reset_mid();
    int n;
    logic seen;
    stall_addr = 5;
    stall_n = 1000000;
    push(1, 6'h00, 32'h1);
    send(5'd2, 8'd8, 8'd8, 1'b0, 1'b0);
    n = 0;
    while (!(mgmt_write && mgmt_address == 6'h05) && n < 100) begin
      @(negedge refclk);
      n++;
    end
    checks++;
    if (!(mgmt_write && mgmt_address == 6'h05)) begin
      errors++;
      $display("FAIL mid_reach: got wr=%0b addr=%h, required stalled write to 05", mgmt_write, mgmt_address);
    end
    repeat (2) @(negedge refclk);
    rst = 1;
    @(negedge refclk);
    checks++;
    if ({mgmt_write, mgmt_read, req_ready, busy, done, err} !== 6'b001000) begin
      errors++;
      $display("FAIL mid_reset: got wr=%0b rd=%0b rdy=%0b busy=%0b done=%0b err=%0b, required 0 0 1 0 0 0",
               mgmt_write, mgmt_read, req_ready, busy, done, err);
    end
    rst = 0;
    stall_n = 0;
    stall_addr = -1;
    seen = 0;
    repeat (20) begin
      @(negedge refclk);
      if (done || err || mgmt_write || mgmt_read) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL mid_quiet: got activity or pulse after reset, required none");
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL mid_sb: got %0d pending transfers, required 0", sb.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish within time limit, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_illegal();
    test_poll_timeout();
    test_lock_timeout();
`ifdef PLL_RECFG_READBACK_EN
    test_readback();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pll_reconfig_master.md
Name: pll_reconfig_master

Overview:
Management-side initiator that drives the Cyclone V PLL reconfiguration controller's Avalon-MM slave, which in turn owns the PLL's reconfig_to_pll/reconfig_from_pll buses. It accepts one counter-change request at a time (M counter or any C0–C17 output counter) and performs the write sequence: mode, counter, start. It then polls for completion and waits for a stable PLL lock. Requests come from the HPS/fabric control logic, so output clocks can be retuned at run time without recompiling the PLL wrapper.

Parameters:
LOCK_STABLE, 16, consecutive cycles pll_locked must be high before success is reported
LOCK_TIMEOUT, 65535, cycles allowed in WAIT_LOCK before lock-timeout error
POLL_LIMIT, 1024, maximum status reads before poll-timeout error

Ports:
refclk  in  1  management clock, also the PLL reference clock (50 MHz)
rst  in  1  synchronous active-high reset
req_valid  in  1  request strobe
req_ready  out  1  high only in IDLE
req_sel  in  5  counter select: 0–17 = C0–C17, 18 = M, 19–31 illegal
req_hi  in  8  high-count divide
req_lo  in  8  low-count divide
req_odd  in  1  odd-divide duty-cycle enable
req_bypass  in  1  counter bypass
mgmt_address  out  6  reconfig controller word address
mgmt_write  out  1  Avalon write
mgmt_read  out  1  Avalon read
mgmt_writedata  out  32  write data
mgmt_readdata  in  32  read data
mgmt_waitrequest  in  1  slave stall
pll_locked  in  1  PLL locked output (pre-synchronised to refclk)
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse on successful completion
err  out  1  one-cycle pulse on failure
err_code  out  2  0 none, 1 poll timeout, 2 lock timeout, 3 illegal select or readback mismatch; held until next accepted request

Behaviour:
- Reset: all outputs 0 except req_ready=1; state IDLE; counters cleared. A reset in mid-operation aborts the operation immediately, drops mgmt_write/mgmt_read in the same cycle, and issues no done or err.
- Request acceptance: a request is accepted on req_valid && req_ready. The fields are latched into a request register. err_code clears to 0 on acceptance. In all non-IDLE states req_ready=0 and req_valid is ignored.
- Illegal select: if req_sel>18, the FSM goes to ERR with err_code=3 and performs no bus activity. err pulses 1 cycle after acceptance.
- Bus rule: address, data and the strobe are held constant while mgmt_waitrequest=1. A transfer completes in the cycle where the strobe is high and waitrequest=0. Readdata is sampled in that same cycle. The strobe drops the following cycle, and strobes are never back-to-back without one idle cycle.
- States:
  - IDLE: on acceptance go to WR_MODE.
  - WR_MODE: write addr 0x00, data 0x1 (polling mode). Then go to WR_CNT.
  - WR_CNT: if sel=18, write addr 0x04 with data {14'b0, odd, bypass, hi, lo}. Otherwise write addr 0x05 with data {9'b0, sel[4:0] at [22:18], odd[17], bypass[16], hi[15:8], lo[7:0]}. Then go to WR_START.
  - WR_START: write addr 0x02, data 0x1. Then go to RD_STATUS.
  - RD_STATUS: read addr 0x01. If readdata[0]=1, go to WAIT_LOCK (or READBACK when the optional feature is compiled in). Otherwise increment the poll count and re-read. When the poll count reaches POLL_LIMIT, go to ERR with err_code=1.
  - WAIT_LOCK: a stable counter increments while pll_locked=1 and clears to 0 when pll_locked=0. When it reaches LOCK_STABLE, go to DONE. Separately, a timeout counter counts every cycle; when it reaches LOCK_TIMEOUT, go to ERR with err_code=2. If both conditions hit in the same cycle, DONE wins.
  - DONE: done=1 for 1 cycle, then IDLE.
  - ERR: err=1 for 1 cycle, then IDLE.
- Counters saturate and never wrap. Both the stable and timeout counters are sized with $clog2(parameter+1).

Optional Feature:
PLL_RECFG_READBACK_EN
- Defined: after status done, a READBACK state re-reads the counter register (0x04 or 0x05) using the same bus rule, and compares readdata[17:0] with the written value. On a match, go to WAIT_LOCK. On a mismatch, go to ERR with err_code=3.
- Undefined: the READBACK state is absent, and RD_STATUS goes directly to WAIT_LOCK.

Test Plan:
- Request sel=2, hi=8, lo=8, waitrequest=0, status done on the 3rd read, locked high → writes (0x00,0x1), (0x05,0x00080808), (0x02,0x1), exactly 3 reads of 0x01, then done pulses LOCK_STABLE cycles after the last read; err_code=0.
- Request sel=18, hi=16, lo=16, odd=1, with waitrequest held high for 5 cycles on every transfer → single write (0x04,0x00021010) held stable through the stall; one strobe per transfer.
- req_sel=25 → err pulse 1 cycle after acceptance, err_code=3, zero mgmt_write/mgmt_read strobes.
- Status bit0 never set, POLL_LIMIT=8 → exactly 8 reads, then err with err_code=1.
- pll_locked toggles every 10 cycles, LOCK_STABLE=16, LOCK_TIMEOUT=200 → err_code=2 at cycle 200 of WAIT_LOCK. Asserting rst mid-WR_CNT with waitrequest=1 → mgmt_write=0 next cycle, req_ready=1, no pulse.
- With PLL_RECFG_READBACK_EN, readback returns 0x00080809 for the first test case → err with err_code=3; without the macro, no readback read occurs.
